// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shift/rotate unit: operation codes, FSM states
// and the flag nibble bit positions used by every ALU block.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_ROL = 2'b01,
    OP_SRL = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/shift_step.sv
// One partial shift/rotate step of 0..STEP bit positions, purely combinational.
// Also reports the last bit pushed out of the far end for the carry flag.
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int STEP = 4,
  localparam int KW  = $clog2(STEP + 1)
) (
  input  logic [SIZE-1:0] data_i,
  input  op_e             op_i,
  input  logic            fill_i,
  input  logic [KW-1:0]   k_i,
  output logic [SIZE-1:0] data_o,
  output logic            last_o
);

  logic [2*SIZE-1:0] doubled;
  logic [2*SIZE-1:0] extended;
  logic [2*SIZE-1:0] wide;

  // Rotations shift a doubled copy so wrapped bits fall into place; SRA shifts a
  // copy whose upper half is the fill bit.
  always_comb begin
    doubled  = {data_i, data_i};
    extended = {{SIZE{fill_i}}, data_i};
    wide     = '0;
    data_o   = data_i;
    unique case (op_i)
      OP_ROR: begin
        wide   = doubled >> k_i;
        data_o = wide[SIZE-1:0];
      end
      OP_ROL: begin
        wide   = doubled << k_i;
        data_o = wide[2*SIZE-1:SIZE];
      end
      OP_SRL: begin
        data_o = data_i >> k_i;
      end
      OP_SRA: begin
        wide   = extended >> k_i;
        data_o = wide[SIZE-1:0];
      end
      default: data_o = data_i;
    endcase
  end

  // Last bit moved out: lsb side for right moves, msb side for ROL. k=0 moves
  // nothing; the caller never uses last_o in that case.
  always_comb begin
    last_o = 1'b0;
    for (int j = 0; j < STEP; j++) begin
      if (int'(k_i) == j + 1) begin
        last_o = (op_i == OP_ROL) ? data_i[SIZE-1-j] : data_i[j];
      end
    end
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: accepts one request over a valid/ready
// handshake, moves at most STEP bit positions per cycle and returns the result
// with the N/Z/V/C flag nibble over a second valid/ready handshake.
module shift_rotate_unit
  import alu_shift_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int M    = 4,
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [SIZE-1:0] in_a,
  input  logic [M-1:0]    in_shift,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out,
  output logic [3:0]      flags_n_z_v_c
);

  localparam int KW = $clog2(STEP + 1);

  state_e          state_q;
  op_e             op_q;
  logic [SIZE-1:0] data_q;
  logic [M-1:0]    rem_q;
  logic            sign_q;
  logic            carry_q;
  logic [SIZE-1:0] out_q;
  logic [3:0]      flags_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [KW-1:0]   k_d;
  logic [M-1:0]    rem_d;
  logic [SIZE-1:0] step_data;
  logic            step_last;

  // Flag nibble derived from a final result and its carry.
  function automatic logic [3:0] make_flags(input logic [SIZE-1:0] r, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[SIZE-1];
    f[FLAG_Z] = ~|r;
    f[FLAG_V] = 1'b0;
    f[FLAG_C] = c;
    return f;
  endfunction

  // Step size for this cycle: whatever is left, capped at STEP.
  always_comb begin
    k_d = KW'(STEP);
    if (int'(rem_q) < STEP) begin
      k_d = KW'(rem_q);
    end
    rem_d = rem_q - M'(k_d);
  end

  shift_step #(
    .SIZE (SIZE),
    .STEP (STEP)
  ) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .fill_i (sign_q),
    .k_i    (k_d),
    .data_o (step_data),
    .last_o (step_last)
  );

  // Control FSM with all outputs registered; result and flags only change on
  // entry to DONE so they hold their value outside the valid window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ROR;
      data_q      <= '0;
      rem_q       <= '0;
      sign_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= op_e'(in_op);
            sign_q     <= in_a[SIZE-1];
            carry_q    <= 1'b0;
            in_ready_q <= 1'b0;
            if (in_shift == '0) begin
              out_q       <= in_a;
              flags_q     <= make_flags(in_a, 1'b0);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              data_q  <= in_a;
              rem_q   <= in_shift;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q  <= step_data;
          rem_q   <= rem_d;
          carry_q <= step_last;
          if (rem_d == '0) begin
            out_q       <= step_data;
            flags_q     <= make_flags(step_data, step_last);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out           = out_q;
  assign flags_n_z_v_c = flags_q;

endmodule
